// File: rtl/mult_pipe_if.sv
// Request/response bundle for mult_pipe: valid/ready request channel carrying
// op, operands and tag, and a valid/ready result channel carrying data and tag.
interface mult_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/mult_pipe.sv
// LATENCY-stage RISC-V style multiplier (MUL/MULH/MULHSU/MULHU) with tag passthrough
// and whole-pipe stall. Define MULT_PIPE_FLUSH_EN to make i_flush squash in-flight work.
module mult_pipe #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 5,
  parameter int TAG_W   = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  mult_pipe_if.slave    bus
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam int         PW        = 2 * XLEN + 2;

  function automatic logic signed [XLEN:0] ext_a(input logic [1:0] op, input logic [XLEN-1:0] a);
    logic sgn;
    sgn = (op != 2'b11) & a[XLEN-1];
    return $signed({sgn, a});
  endfunction

  function automatic logic signed [XLEN:0] ext_b(input logic [1:0] op, input logic [XLEN-1:0] b);
    logic sgn;
    sgn = ((op == OP_MUL) || (op == OP_MULH)) & b[XLEN-1];
    return $signed({sgn, b});
  endfunction

  function automatic logic [XLEN-1:0] sel_result(input logic [1:0] op, input logic [2*XLEN-1:0] prod);
    if (op == OP_MUL) return prod[XLEN-1:0];
    return prod[2*XLEN-1:XLEN];
  endfunction

  logic [LATENCY-1:0]      r_vld;
  logic signed [XLEN:0]    r_a_p0;
  logic signed [XLEN:0]    r_b_p0;
  logic [1:0]              r_op_p0;
  logic [TAG_W-1:0]        r_tag_p [0:LATENCY-1];
  logic [XLEN-1:0]         r_res_p [1:LATENCY-1];

  logic                    w_adv;
  logic                    w_acc;
  logic                    w_kill;
  logic signed [PW-1:0]    w_a_wide;
  logic signed [PW-1:0]    w_b_wide;
  logic signed [PW-1:0]    w_prod_full;
  logic [2*XLEN-1:0]       w_prod;
  logic [1:0]              w_unused_prod_top;

`ifdef MULT_PIPE_FLUSH_EN
  assign w_kill = i_flush;
`else
  logic w_unused_flush;
  assign w_unused_flush = i_flush;
  assign w_kill         = 1'b0;
`endif

  // The pipe only moves when the result slot is empty or being drained.
  assign w_adv         = !r_vld[LATENCY-1] || bus.out_ready;
  assign w_acc         = bus.in_valid && w_adv;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld[LATENCY-1];
  assign bus.out_data  = r_res_p[LATENCY-1];
  assign bus.out_tag   = r_tag_p[LATENCY-1];

  // Sign-extend to full product width so the low 2*XLEN bits are exact for every op.
  assign w_a_wide          = $signed({{(XLEN+1){r_a_p0[XLEN]}}, r_a_p0});
  assign w_b_wide          = $signed({{(XLEN+1){r_b_p0[XLEN]}}, r_b_p0});
  assign w_prod_full       = w_a_wide * w_b_wide;
  assign w_prod            = w_prod_full[2*XLEN-1:0];
  assign w_unused_prod_top = w_prod_full[PW-1:2*XLEN];

  always_ff @(posedge i_clk) begin
    if (i_rst || w_kill) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld <= {r_vld[LATENCY-2:0], w_acc};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_adv) begin
      // p0: extended operands
      r_a_p0     <= ext_a(bus.in_op, bus.in_a);
      r_b_p0     <= ext_b(bus.in_op, bus.in_b);
      r_op_p0    <= bus.in_op;
      r_tag_p[0] <= bus.in_tag;
      // p1: selected product half
      r_res_p[1] <= sel_result(r_op_p0, w_prod);
      // p2..: delay stages
      for (int i = 2; i < LATENCY; i++) begin
        r_res_p[i] <= r_res_p[i-1];
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_p[i] <= r_tag_p[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe: the driver queues expected results on acceptance,
// a negedge monitor pops and compares whenever a result is handed off.
module tb_mult_pipe;
  localparam int XLEN    = 32;
  localparam int LATENCY = 5;
  localparam int TAG_W   = 6;
  localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  mult_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();

  mult_pipe #(.XLEN(XLEN), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_flush(flush),
    .bus    (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  bit   done_send;

  localparam logic [1:0]  V_OP  [12] = '{MULH, MULHSU, MULHU, MUL, MUL, MULH,
                                         MULHSU, MULHU, MULH, MULHSU, MULH, MUL};
  localparam logic [31:0] V_A   [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7,
                                         32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,
                                         32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h00010000};
  localparam logic [31:0] V_B   [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd6,
                                         32'd5, 32'h80000000, 32'd2, 32'd2,
                                         32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000};
  localparam logic [31:0] V_EXP [12] = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd42,
                                         32'hFFFFFFF1, 32'h40000000, 32'hFFFFFFFF, 32'h00000001,
                                         32'h3FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000000};
  localparam logic [31:0] B2B_EXP [8] = '{32'd3, 32'd8, 32'd15, 32'd24, 32'd35, 32'd48, 32'd63, 32'd80};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic [31:0] exp, input bit push);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.data = exp;
        e.tag  = tag;
        if (push) sb.push_back(e);
        tick();
        bus.in_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL send_timeout: tag %0d never accepted", tag);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    n_checks++;
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0 && !bus.out_valid) return;
      tick();
    end
    n_errors++;
    $display("FAIL %s_drain: %0d results still pending", name, sb.size());
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: tag %0d data %0h with nothing outstanding",
                   bus.out_tag, bus.out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e.data));
          chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
        end
      end
    end
  end

  initial begin
    int base;
    bit seen;
    bus.in_valid  = 1'b0;
    bus.in_op     = MUL;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // MUL latency and low half
    send(MUL, 32'hFFFFFFFF, 32'h00000002, 6'd1, 32'hFFFFFFFE, 1'b1);
    repeat (LATENCY - 2) @(posedge clk);
    #1;
    chk("latency_early", 64'(bus.out_valid), 64'd0);
    tick();
    chk("latency_hit", 64'(bus.out_valid), 64'd1);
    wait_drain("mul");

    // Directed op table, back to back
    for (int i = 0; i < 12; i++) send(V_OP[i], V_A[i], V_B[i], 6'(10 + i), V_EXP[i], 1'b1);
    wait_drain("table");

    // 8 back-to-back with out_ready toggling
    base = n_out;
    done_send = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(MUL, 32'(i + 1), 32'(i + 3), 6'(i), B2B_EXP[i], 1'b1);
        done_send = 1'b1;
      end
      begin
        while (!done_send) begin
          @(posedge clk);
          #1;
          bus.out_ready = ~bus.out_ready;
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain("b2b");
    chk("b2b_count", 64'(n_out - base), 64'd8);

    // Stall with three in flight
    bus.out_ready = 1'b0;
    send(MUL, 32'd3, 32'd3, 6'd20, 32'd9, 1'b1);
    send(MUL, 32'd4, 32'd4, 6'd21, 32'd16, 1'b1);
    send(MUL, 32'd5, 32'd5, 6'd22, 32'd25, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    chk("stall_out_valid", 64'(seen), 64'd1);
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_hold_data", 64'(bus.out_data), 64'd9);
      chk("stall_hold_tag", 64'(bus.out_tag), 64'd20);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("release_consecutive", 64'(bus.out_valid), 64'd1);
    end
    tick();
    wait_drain("stall");

    // Flush with three in flight plus a same-cycle request
    base = n_out;
`ifdef MULT_PIPE_FLUSH_EN
    send(MUL, 32'd2, 32'd3, 6'd30, 32'd6, 1'b0);
    send(MUL, 32'd2, 32'd4, 6'd31, 32'd8, 1'b0);
    send(MUL, 32'd2, 32'd5, 6'd32, 32'd10, 1'b0);
`else
    send(MUL, 32'd2, 32'd3, 6'd30, 32'd6, 1'b1);
    send(MUL, 32'd2, 32'd4, 6'd31, 32'd8, 1'b1);
    send(MUL, 32'd2, 32'd5, 6'd32, 32'd10, 1'b1);
`endif
    bus.in_valid = 1'b1;
    bus.in_op    = MUL;
    bus.in_a     = 32'd2;
    bus.in_b     = 32'd6;
    bus.in_tag   = 6'd33;
    flush        = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
`ifndef MULT_PIPE_FLUSH_EN
    sb.push_back('{data: 32'd12, tag: 6'd33});
`endif
    tick();
    bus.in_valid = 1'b0;
    flush        = 1'b0;
`ifdef MULT_PIPE_FLUSH_EN
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < LATENCY + 2; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush_quiet", 64'(seen), 64'd0);
    tick();
    send(MUL, 32'd9, 32'd9, 6'd34, 32'd81, 1'b1);
    wait_drain("flush");
    chk("flush_count", 64'(n_out - base), 64'd1);
`else
    wait_drain("flush");
    chk("flush_count", 64'(n_out - base), 64'd4);
`endif

    // Reset with two in flight; a request held during reset must be dropped
    send(MUL, 32'd11, 32'd12, 6'd40, 32'd132, 1'b0);
    send(MUL, 32'd13, 32'd14, 6'd41, 32'd182, 1'b0);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 32'd5;
    bus.in_b     = 32'd5;
    bus.in_tag   = 6'd42;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    send(MUL, 32'd7, 32'd6, 6'd43, 32'd42, 1'b1);
    wait_drain("rst_mid");

    repeat (LATENCY + 2) tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mult_pipe.md
MULT_PIPE -- requirements
Module: mult_pipe

Interface
REQ-001 Parameter XLEN, default 32: operand and result width in bits, at least 8.
REQ-002 Parameter LATENCY, default 5: pipeline depth in stages, at least 2.
REQ-003 Parameter TAG_W, default 6: width of the destination tag carried alongside each operation.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  squash every in-flight operation.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-009 in_op  input  2  operation select: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-010 in_a, in_b  input  XLEN each  operands (rs1, rs2).
REQ-011 in_tag  input  TAG_W  destination tag.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_data  output  XLEN  result.
REQ-015 out_tag  output  TAG_W  tag of the result.

Function
REQ-016 Pipeline: LATENCY stages; each stage holds valid, op, tag and partial-product state.
REQ-017 Latency: with no stall, a request accepted at edge t SHALL show out_valid=1 after edge t+LATENCY-1, i.e. visible for LATENCY cycles counted from acceptance.
REQ-018 Throughput: one request per cycle while out_ready=1.
REQ-019 Stall: whole pipeline freezes when last-stage valid=1 and out_ready=0; bubbles are not compressed.
REQ-020 in_ready = !last_valid || out_ready; combinational, no dependence on in_valid.
REQ-021 A result is held stable (out_data, out_tag) while out_valid=1 and out_ready=0.
REQ-022 Results leave in acceptance order; tags pass through unmodified.
REQ-023 Arithmetic: each operand extends to XLEN+1 bits (MUL/MULH: a,b signed; MULHSU: a signed, b unsigned; MULHU: both unsigned); form the 2*XLEN-bit product.
REQ-024 MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
REQ-025 No overflow trap and no exception output; all operand values are legal.
REQ-026 Flush (when enabled): clears every stage valid at the next edge; a request presented in the same cycle as flush is discarded; out_valid=0 the cycle after flush.
REQ-027 Flush with a stalled result: the result is dropped, never delivered.
REQ-028 Flush and reset together: reset behaviour applies.
REQ-029 out_data and out_tag are don't-care when out_valid=0.

Reset
REQ-030 Reset clears all stage valid bits; out_valid=0 and in_ready=1 in the cycle following reset.
REQ-031 Reset mid-operation discards all in-flight work; a request presented during reset is not accepted.
REQ-032 Datapath registers need no reset.

Configuration
REQ-033 Macro MULT_PIPE_FLUSH_EN: when defined, flush behaves as REQ-026..REQ-028.
REQ-034 Without MULT_PIPE_FLUSH_EN: the flush port remains, is ignored, and in-flight operations always complete.

Verification
REQ-035 XLEN=32, MUL a=0xFFFFFFFF, b=0x00000002 -> 0xFFFFFFFE, LATENCY cycles after acceptance.
REQ-036 MULH, MULHSU, MULHU, each with a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively.
REQ-037 Back-to-back 8 requests with tags 0..7, out_ready toggled 1/0 each cycle -> all 8 results delivered in order with correct tags; no loss or duplicate.
REQ-038 Hold out_ready=0 with 3 requests in flight -> in_ready falls when the last stage fills; out_data stays stable; after release, results emerge on consecutive cycles.
REQ-039 With MULT_PIPE_FLUSH_EN: flush with 3 in flight plus a new request in the same cycle -> no out_valid until a new request is accepted afterwards; without the macro, all 4 complete.
REQ-040 Assert reset while 2 ops are in flight -> out_valid=0 the next cycle; a subsequent MUL 7*6 returns 42.
